// File: rtl/pc_sequencer.sv
// Program counter, PC link registers and IDLE/RUN/DONE run control for the 9-bit-ISA core.
// One instruction retires per RUN cycle; CycleCount measures the RUN time of the current program.
module pc_sequencer #(
    parameter int                 PC_W       = 10,
    parameter logic [PC_W-1:0]    START_ADDR = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic             ZeroFlag,
    input  logic [7:0]       Offset,
    output logic [PC_W-1:0]  ProgCounter,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   lr1_q, lr2_q, lr3_q;
    logic [PC_W-1:0]   lr_rdata;
    logic [PC_W-1:0]   lr_wdata;
    logic [PC_W-1:0]   offset_ext;
    logic [PC_W-1:0]   pc_inc;
    logic              lr_we;
    logic              is_jump;
    logic              taken;

    assign offset_ext = PC_W'(Offset);
    assign pc_inc     = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign is_jump    = JumpEqual | JumpNotEqual;
    // Both jump flags together form an unconditional jump.
    assign taken      = (JumpEqual & ZeroFlag) | (JumpNotEqual & ~ZeroFlag);

    always_comb begin
        lr_rdata = '0;
        case (PCRegSelect)
            2'b01:   lr_rdata = lr1_q;
            2'b10:   lr_rdata = lr2_q;
            2'b11:   lr_rdata = lr3_q;
            default: lr_rdata = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            lr1_q   <= '0;
            lr2_q   <= '0;
            lr3_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            if (lr_we) begin
                case (PCRegSelect)
                    2'b01:   lr1_q <= lr_wdata;
                    2'b10:   lr2_q <= lr_wdata;
                    2'b11:   lr3_q <= lr_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        lr_we    = 1'b0;
        lr_wdata = pc_inc;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // The halt cycle itself is counted as a RUN cycle.
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (Halt) begin
                    state_d = DONE;
                end else if (is_jump) begin
                    pc_d = (taken && PCRegSelect != 2'b00) ? lr_rdata : pc_inc;
                end else begin
                    pc_d = pc_inc;
                    if (PCRegSelect != 2'b00) begin
                        lr_we    = 1'b1;
                        lr_wdata = OffsetEn ? (pc_q + offset_ext) : pc_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ProgCounter = pc_q;
    assign Running     = (state_q == RUN);
    assign Done        = (state_q == DONE);
    assign CycleCount  = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main program flow plus
// hand-written sequences for halt timing, PC wrap-around and reset during a run.
module tb_pc_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start, Halt, JumpEqual, JumpNotEqual, OffsetEn, ZeroFlag;
    logic [1:0]       PCRegSelect;
    logic [7:0]       Offset;
    logic [PC_W-1:0]  ProgCounter;
    logic             Running, Done;
    logic [CNT_W-1:0] CycleCount;
    logic [1:0]       state_dbg;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.PC_W(PC_W), .START_ADDR('0), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .OffsetEn(OffsetEn),
        .PCRegSelect(PCRegSelect), .ZeroFlag(ZeroFlag), .Offset(Offset),
        .ProgCounter(ProgCounter), .Running(Running), .Done(Done),
        .CycleCount(CycleCount), .state_dbg(state_dbg)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       start, halt, je, jne, offen;
        logic [1:0] sel;
        logic       zero;
        logic [7:0] offset;
        int         exp_pc, exp_run, exp_done, exp_cnt;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic st, input logic h, input logic je, input logic jne,
                                input logic oe, input logic [1:0] sel, input logic z,
                                input logic [7:0] off, input int pc, input int run,
                                input int dn, input int cnt);
        vec_t v;
        v.start = st; v.halt = h; v.je = je; v.jne = jne; v.offen = oe;
        v.sel = sel; v.zero = z; v.offset = off;
        v.exp_pc = pc; v.exp_run = run; v.exp_done = dn; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic st, input logic h, input logic je, input logic jne,
                        input logic oe, input logic [1:0] sel, input logic z, input logic [7:0] off);
        Start = st; Halt = h; JumpEqual = je; JumpNotEqual = jne;
        OffsetEn = oe; PCRegSelect = sel; ZeroFlag = z; Offset = off;
        @(posedge Clk);
        #1;
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    endtask

    task automatic check_all(input string tag, input int pc, input int run,
                             input int dn, input int cnt);
        check({tag, " pc"},      32'(ProgCounter), 32'(pc));
        check({tag, " running"}, 32'(Running),     32'(run));
        check({tag, " done"},    32'(Done),        32'(dn));
        check({tag, " count"},   32'(CycleCount),  32'(cnt));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        nop();
        Reset = 1'b0;
    endtask

    initial begin
        // start halt je jne offen sel zero offset | pc run done cnt
        vecs[0]  = mk(0,0,1,0,0,2'd1,1,8'd0,   0,0,0,0);   // IDLE ignores instruction inputs
        vecs[1]  = mk(1,0,0,0,0,2'd0,0,8'd0,   0,1,0,0);
        vecs[2]  = mk(0,0,0,0,0,2'd0,0,8'd0,   1,1,0,1);
        vecs[3]  = mk(0,0,0,0,0,2'd0,0,8'd0,   2,1,0,2);
        vecs[4]  = mk(0,0,0,0,0,2'd1,0,8'd0,   3,1,0,3);   // LR1 = 3
        vecs[5]  = mk(0,0,0,0,1,2'd2,0,8'd5,   4,1,0,4);   // LR2 = 3+5 = 8
        vecs[6]  = mk(0,0,0,0,0,2'd0,0,8'd0,   5,1,0,5);
        vecs[7]  = mk(0,0,0,1,0,2'd1,1,8'd0,   6,1,0,6);   // jne, zero set: not taken
        vecs[8]  = mk(0,0,1,0,0,2'd2,1,8'd0,   8,1,0,7);   // je taken -> LR2
        vecs[9]  = mk(0,0,0,1,0,2'd1,0,8'd0,   3,1,0,8);   // jne taken -> LR1
        vecs[10] = mk(0,0,0,0,0,2'd0,0,8'd0,   4,1,0,9);
        vecs[11] = mk(0,0,0,0,0,2'd0,0,8'd0,   5,1,0,10);
        vecs[12] = mk(0,0,0,0,0,2'd0,0,8'd0,   6,1,0,11);
        vecs[13] = mk(0,0,1,0,0,2'd2,0,8'd0,   7,1,0,12);  // je not taken
        vecs[14] = mk(0,0,0,1,0,2'd0,0,8'd0,   8,1,0,13);  // taken, select 00 -> PC+1
        vecs[15] = mk(0,0,1,1,0,2'd1,0,8'd0,   3,1,0,14);  // both flags: always taken
        vecs[16] = mk(0,1,1,0,0,2'd2,1,8'd0,   3,0,1,15);  // halt beats jump
        vecs[17] = mk(0,0,1,0,0,2'd1,1,8'd0,   3,0,1,15);  // DONE holds
        vecs[18] = mk(1,0,0,0,0,2'd0,0,8'd0,   0,1,0,0);   // restart
        vecs[19] = mk(0,0,1,0,0,2'd1,1,8'd0,   3,1,0,1);   // LR1 retained
        vecs[20] = mk(0,0,1,0,0,2'd2,1,8'd0,   8,1,0,2);   // LR2 retained
        vecs[21] = mk(1,1,0,0,1,2'd3,0,8'd0,   8,0,1,3);   // halt suppresses save to LR3
        vecs[22] = mk(1,0,0,0,0,2'd0,0,8'd0,   0,1,0,0);   // Start held relaunches
        vecs[23] = mk(1,0,1,0,0,2'd3,1,8'd0,   0,1,0,1);   // LR3 still 0, Start ignored
        vecs[24] = mk(0,0,0,0,0,2'd0,0,8'd0,   1,1,0,2);

        Start = 0; Halt = 0; JumpEqual = 0; JumpNotEqual = 0; OffsetEn = 0;
        PCRegSelect = 2'b00; ZeroFlag = 0; Offset = 8'd0;
        Reset = 1'b1;
        nop();
        nop();
        Reset = 1'b0;
        check_all("reset", 0, 0, 0, 0);
        check("reset state", 32'(state_dbg), 32'd0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].start, vecs[i].halt, vecs[i].je, vecs[i].jne,
                 vecs[i].offen, vecs[i].sel, vecs[i].zero, vecs[i].offset);
            check_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_run,
                      vecs[i].exp_done, vecs[i].exp_cnt);
        end

        // Halt on the 10th RUN cycle, with a taken je alongside.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        for (int i = 0; i < 9; i++) nop();
        check_all("pre_halt", 9, 1, 0, 9);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'd0);
        check_all("halt", 9, 0, 1, 10);
        check("halt state", 32'(state_dbg), 32'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        check_all("halt_restart", 0, 1, 0, 0);

        // PC wrap and offset wrap into LR3.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        for (int i = 0; i < 1020; i++) nop();
        check_all("wrap_1020", 1020, 1, 0, 1020);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 8'd10);
        nop();
        nop();
        check_all("wrap_1023", 1023, 1, 0, 1023);
        nop();
        check_all("wrap_0", 0, 1, 0, 1024);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 8'd0);
        check_all("wrap_lr3", 6, 1, 0, 1025);

        // Reset during RUN clears link registers and counter.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        nop();
        nop();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'd0);
        nop();
        nop();
        check_all("pre_reset", 5, 1, 0, 5);
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'd0);
        Reset = 1'b0;
        check_all("mid_reset", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        check_all("post_reset_start", 0, 1, 0, 0);
        nop();
        nop();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'd0);
        check_all("post_reset_lr1", 0, 1, 0, 3);
        nop();
        check_all("post_reset_step", 1, 1, 0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program counter and run-control FSM for the single-cycle 9-bit-ISA core.
- Holds the three PC link registers (PCreg1–PCreg3) written by spc and consumed by je/jne.
- Runs the start/done handshake with the testbench and counts cycles spent executing.
- Inputs come combinationally from the control decoder, the ALU zero flag and the r8 read port. ProgCounter feeds the instruction ROM.

Parameters:
PC_W, 10, program counter and link register width (instruction ROM depth 2^PC_W)
START_ADDR, 0, PC value loaded on reset and on every program start
CNT_W, 16, cycle counter width

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request to begin execution (sampled in IDLE/DONE)
Halt  input  1  decoder Ack; current instruction is the halt encoding (all ones)
JumpEqual  input  1  current instruction is je
JumpNotEqual  input  1  current instruction is jne
OffsetEn  input  1  spc saves PC+Offset instead of PC+1
PCRegSelect  input  2  link register select: 00 none, 01/10/11 = LR1/LR2/LR3
ZeroFlag  input  1  ALU zero flag, valid same cycle
Offset  input  8  r8 value, unsigned
ProgCounter  output  PC_W  current instruction address (registered)
Running  output  1  high while state = RUN
Done  output  1  high while state = DONE
CycleCount  output  CNT_W  cycles spent in RUN for the current/last program

Behaviour:
- **Reset** (sync, priority over everything):
  - state=IDLE, ProgCounter=START_ADDR, LR1..LR3=0, CycleCount=0.
  - Running=0, Done=0.
  - A reset asserted mid-RUN behaves identically and takes effect on the next edge.
- **FSM states** IDLE, RUN, DONE. Running and Done are decoded directly from the state register (no extra latency).
- **IDLE:**
  - Start=1 -> RUN, ProgCounter<=START_ADDR, CycleCount<=0.
  - Otherwise hold.
  - All instruction-derived inputs are ignored.
- **RUN:** one instruction executes per cycle. Priority order:
  1. Halt=1 -> DONE. ProgCounter holds, no LR write. Halt overrides any jump or save bits.
  2. Jump (JumpEqual or JumpNotEqual high):
     - taken = (JumpEqual & ZeroFlag) | (JumpNotEqual & ~ZeroFlag).
     - If both flags are high, the jump is unconditionally taken.
     - Taken and PCRegSelect!=0 -> ProgCounter<=LR[PCRegSelect].
     - Not taken, or PCRegSelect=00 -> ProgCounter<=ProgCounter+1.
     - No LR write on any jump instruction.
  3. Save (no jump flag, PCRegSelect!=0):
     - LR[PCRegSelect] <= ProgCounter + (OffsetEn ? zero-extended Offset : 1).
     - ProgCounter<=ProgCounter+1.
  4. Otherwise ProgCounter<=ProgCounter+1.
  - Start is ignored in RUN.
- **Arithmetic:** all PC/LR additions are modulo 2^PC_W. PC at 2^PC_W-1 increments to 0, and offset sums wrap the same way.
- **Jump to a just-saved LR:** a jump reads the LR value registered before the current edge. Save and jump are distinct instructions, so no same-cycle forwarding is required.
- **CycleCount:**
  - Increments by 1 on every edge where the state is RUN, including the Halt cycle.
  - Saturates at 2^CNT_W-1.
  - Frozen in DONE and IDLE.
  - Cleared only on entry to RUN or on reset.
- **DONE:**
  - Done=1; ProgCounter, LRs and CycleCount are held.
  - Start=1 -> RUN with ProgCounter<=START_ADDR and CycleCount<=0.
  - LRs are retained across restarts; only Reset clears them.
  - Start held high continuously after Halt re-launches on the next edge.

Test Plan:
- **Straight-line run:** Reset 1 cycle, Start pulse 1 cycle -> Running=1 next cycle; ProgCounter 0,1,2,3… on successive edges; Done=0.
- **Save then je:**
  - At PC=3 drive PCRegSelect=10, OffsetEn=1, Offset=5 -> LR2=8, PC=4.
  - At PC=6 drive JumpEqual=1, ZeroFlag=1, PCRegSelect=10 -> PC=8.
  - Repeat with ZeroFlag=0 -> PC=7.
- **jne paths:**
  - spc at PC=2 with OffsetEn=0, select 01 -> LR1=3.
  - jne with ZeroFlag=1 at PC=5 -> PC=6.
  - jne with ZeroFlag=0, select 01 -> PC=3.
  - jne with select 00 -> PC+1.
- **Wrap:**
  - Run to PC=1023 -> next PC=0.
  - spc at PC=1020, OffsetEn=1, Offset=10, select 11 -> LR3=6.
- **Halt/restart:**
  - Halt asserted at PC=9 (10th RUN cycle) together with JumpEqual=1, ZeroFlag=1 -> DONE next edge, PC stays 9, CycleCount=10, no jump.
  - Start pulse -> PC=0, CycleCount=0, LRs unchanged.
- **Reset mid-run:** assert Reset at PC=5 with LR1=3 -> next edge IDLE, PC=0, LR1..LR3=0, CycleCount=0, Running=0; Start afterwards resumes normally.
